// File: rtl/link_sprite_ctrl_if.sv
// Player-sprite controller bus: motion/raster inputs, sprite ROM port and
// colour-mapper output.
//   master : the sprite controller (drives rom_sel, rom_addr, pixel_index, pixel_valid)
//   slave  : the surrounding game logic, raster timing, ROM and colour mapper
interface link_sprite_ctrl_if #(
  parameter int unsigned SPRITE_SIZE = 16
);
  localparam int unsigned AW = 2 * $clog2(SPRITE_SIZE);

  logic          frame_tick;
  logic [1:0]    dir_req;
  logic          moving;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic [9:0]    LinkX;
  logic [9:0]    LinkY;
  logic [3:0]    rom_index;
  logic [2:0]    rom_sel;
  logic [AW-1:0] rom_addr;
  logic [3:0]    pixel_index;
  logic          pixel_valid;

  modport master (
    input  frame_tick, dir_req, moving, DrawX, DrawY, LinkX, LinkY, rom_index,
    output rom_sel, rom_addr, pixel_index, pixel_valid
  );

  modport slave (
    output frame_tick, dir_req, moving, DrawX, DrawY, LinkX, LinkY, rom_index,
    input  rom_sel, rom_addr, pixel_index, pixel_valid
  );
endinterface

// File: rtl/link_sprite_ctrl.sv
// Player-sprite sequencer: latches facing and walk-animation frame once per
// video frame, turns the raster position into a sprite ROM address, and
// resolves sprite coverage/transparency into a registered palette index.
//   Clk, Reset_n : pixel clock, async active-low reset
//   bus (master) : frame_tick/dir_req/moving, DrawX/DrawY, LinkX/LinkY,
//                  rom_index in; rom_sel, rom_addr, pixel_index, pixel_valid out
module link_sprite_ctrl #(
  parameter int unsigned SPRITE_SIZE       = 16,
  parameter int unsigned ANIM_PERIOD       = 8,
  parameter int unsigned TRANSPARENT_INDEX = 0
) (
  input  logic                Clk,
  input  logic                Reset_n,
  link_sprite_ctrl_if.master  bus
);
  localparam int unsigned K  = $clog2(SPRITE_SIZE);
  localparam int unsigned AW = 2 * K;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_PERIOD - 1);
  localparam logic [3:0]    TRANSP   = 4'(TRANSPARENT_INDEX);
  localparam logic [10:0]   SIZE11   = 11'(SPRITE_SIZE);

  typedef enum logic [1:0] {
    ST_STAND  = 2'd0,
    ST_WALK_A = 2'd1,
    ST_WALK_B = 2'd2
  } anim_state_e;

  anim_state_e   state_q,   state_d;
  logic [CW-1:0] anim_cnt_q, anim_cnt_d;
  logic [1:0]    dir_q,     dir_d;
  logic [2:0]    rom_sel_q, rom_sel_d;

  logic [10:0]   dx, dy;
  logic          hit;
  logic [AW-1:0] rom_addr_d, rom_addr_q;
  logic          hit_d1_q;
  logic [3:0]    pixel_index_q;
  logic          pixel_valid_q;

  // Animation/direction state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_STAND;
      anim_cnt_q <= '0;
      dir_q      <= 2'd1;
      rom_sel_q  <= 3'b010;
    end else begin
      state_q    <= state_d;
      anim_cnt_q <= anim_cnt_d;
      dir_q      <= dir_d;
      rom_sel_q  <= rom_sel_d;
    end
  end

  // Next state: everything moves only on frame_tick so a frame never tears
  always_comb begin
    state_d    = state_q;
    anim_cnt_d = anim_cnt_q;
    dir_d      = dir_q;
    rom_sel_d  = rom_sel_q;
    if (bus.frame_tick) begin
      dir_d = bus.dir_req;
      case (state_q)
        ST_STAND: begin
          if (bus.moving) begin
            state_d    = ST_WALK_A;
            anim_cnt_d = '0;
          end
        end
        ST_WALK_A, ST_WALK_B: begin
          if (!bus.moving) begin
            state_d    = ST_STAND;
            anim_cnt_d = '0;
          end else if (anim_cnt_q == CNT_LAST) begin
            anim_cnt_d = '0;
            state_d    = (state_q == ST_WALK_A) ? ST_WALK_B : ST_WALK_A;
          end else begin
            anim_cnt_d = anim_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d    = ST_STAND;
          anim_cnt_d = '0;
        end
      endcase
      rom_sel_d = {dir_d, (state_d == ST_WALK_B)};
    end
  end

  // Hit test; 11-bit difference so a raster position left/above the sprite
  // shows up as a set sign bit instead of wrapping into the box
  always_comb begin
    dx         = {1'b0, bus.DrawX} - {1'b0, bus.LinkX};
    dy         = {1'b0, bus.DrawY} - {1'b0, bus.LinkY};
    hit        = !dx[10] && (dx < SIZE11) && !dy[10] && (dy < SIZE11);
    rom_addr_d = {dy[K-1:0], dx[K-1:0]};
  end

  // Two-stage pixel pipeline: address/hit, then ROM data resolved to index
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q    <= '0;
      hit_d1_q      <= 1'b0;
      pixel_index_q <= 4'd0;
      pixel_valid_q <= 1'b0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      hit_d1_q      <= hit;
      pixel_index_q <= hit_d1_q ? bus.rom_index : TRANSP;
      pixel_valid_q <= hit_d1_q && (bus.rom_index != TRANSP);
    end
  end

  assign bus.rom_sel     = rom_sel_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.pixel_index = pixel_index_q;
  assign bus.pixel_valid = pixel_valid_q;
endmodule

// File: tb/tb_link_sprite_ctrl.sv
// Self-checking bench for link_sprite_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// frame-count based behavioural model. A second instance runs ANIM_PERIOD=1.
module tb_link_sprite_ctrl;
  localparam int TI = 0;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   cmp_en;

  link_sprite_ctrl_if #(.SPRITE_SIZE(16)) bus  ();
  link_sprite_ctrl_if #(.SPRITE_SIZE(16)) bus1 ();

  assign bus1.frame_tick = bus.frame_tick;
  assign bus1.dir_req    = bus.dir_req;
  assign bus1.moving     = bus.moving;
  assign bus1.DrawX      = bus.DrawX;
  assign bus1.DrawY      = bus.DrawY;
  assign bus1.LinkX      = bus.LinkX;
  assign bus1.LinkY      = bus.LinkY;
  assign bus1.rom_index  = bus.rom_index;

  link_sprite_ctrl #(.SPRITE_SIZE(16), .ANIM_PERIOD(8), .TRANSPARENT_INDEX(TI)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus.master)
  );

  link_sprite_ctrl #(.SPRITE_SIZE(16), .ANIM_PERIOD(1), .TRANSPARENT_INDEX(TI)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: facing and count of consecutive walking ticks; frame parity
  // follows from how many whole animation periods have elapsed.
  logic [1:0] m_dir;
  int         walk_ticks;
  logic       p_hit;
  logic [7:0] e_addr;
  logic [3:0] e_idx;
  logic       e_val;

  function automatic logic frame_of(input int wt, input int period);
    if (wt == 0) return 1'b0;
    return 1'(((wt - 1) / period) % 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dir      <= 2'd1;
      walk_ticks <= 0;
      p_hit      <= 1'b0;
      e_addr     <= 8'd0;
      e_idx      <= 4'd0;
      e_val      <= 1'b0;
    end else begin
      automatic int dx = int'(bus.DrawX) - int'(bus.LinkX);
      automatic int dy = int'(bus.DrawY) - int'(bus.LinkY);
      e_val  <= p_hit && (int'(bus.rom_index) != TI);
      e_idx  <= p_hit ? bus.rom_index : 4'(TI);
      p_hit  <= (dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16);
      e_addr <= 8'(((dy & 15) << 4) | (dx & 15));
      if (bus.frame_tick) begin
        m_dir      <= bus.dir_req;
        walk_ticks <= bus.moving ? walk_ticks + 1 : 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rom_sel",      32'(bus.rom_sel),      32'({m_dir, frame_of(walk_ticks, 8)}));
      chk("rom_addr",     32'(bus.rom_addr),     32'(e_addr));
      chk("pixel_index",  32'(bus.pixel_index),  32'(e_idx));
      chk("pixel_valid",  32'(bus.pixel_valid),  32'(e_val));
      chk("p1_rom_sel",   32'(bus1.rom_sel),     32'({m_dir, frame_of(walk_ticks, 1)}));
      chk("p1_pix_valid", 32'(bus1.pixel_valid), 32'(e_val));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    cmp_en         = 1'b0;
    bus.frame_tick = 1'b0;
    bus.dir_req    = 2'd1;
    bus.moving     = 1'b0;
    bus.DrawX      = '0;
    bus.DrawY      = '0;
    bus.LinkX      = '0;
    bus.LinkY      = '0;
    bus.rom_index  = '0;
    rst_n          = 1'b1;
    #1 rst_n       = 1'b0;
    #1 cmp_en      = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Whole raster line with no ticks, sprite at origin, transparent data
    for (int x = 0; x < 800; x++) begin
      bus.DrawX = 10'(x);
      cyc();
    end
    @(negedge clk);
    chk("idle_rom_sel", 32'(bus.rom_sel), 32'd2);
    chk("idle_valid",   32'(bus.pixel_valid), 32'd0);

    // Horizontal sweep across the sprite box
    bus.LinkX     = 10'd100;
    bus.LinkY     = 10'd50;
    bus.DrawY     = 10'd55;
    bus.rom_index = 4'd5;
    for (int x = 98; x <= 118; x++) begin
      bus.DrawX = 10'(x);
      cyc();
      if (x == 103) begin
        @(negedge clk);
        chk("addr_103", 32'(bus.rom_addr), 32'd83);
      end
      cyc();
      @(negedge clk);
      chk("sweep_valid", 32'(bus.pixel_valid), 32'((x >= 100) && (x <= 115)));
      if (x >= 100 && x <= 115) chk("sweep_index", 32'(bus.pixel_index), 32'd5);
    end

    // Two-cycle latency from a miss to a hit
    bus.DrawX = 10'd90;
    repeat (3) cyc();
    bus.DrawX = 10'd100;
    @(negedge clk); chk("lat0", 32'(bus.pixel_valid), 32'd0);
    cyc(); @(negedge clk); chk("lat1", 32'(bus.pixel_valid), 32'd0);
    cyc(); @(negedge clk); chk("lat2", 32'(bus.pixel_valid), 32'd1);

    // Transparent data inside the box
    bus.rom_index = 4'd0;
    bus.DrawX     = 10'd105;
    cyc(); cyc();
    @(negedge clk);
    chk("transp_valid", 32'(bus.pixel_valid), 32'd0);
    chk("transp_index", 32'(bus.pixel_index), 32'd0);

    // Walk animation facing right
    bus.moving  = 1'b1;
    bus.dir_req = 2'd3;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1)  chk("anim_t1",  32'(bus.rom_sel), 32'd6);
      if (i == 8)  chk("anim_t8",  32'(bus.rom_sel), 32'd6);
      if (i == 9)  chk("anim_t9",  32'(bus.rom_sel), 32'd7);
      if (i == 16) chk("anim_t16", 32'(bus.rom_sel), 32'd7);
      if (i == 17) chk("anim_t17", 32'(bus.rom_sel), 32'd6);
      if (i == 2)  chk("p1_t2",    32'(bus1.rom_sel), 32'd7);
      repeat (3) cyc();
    end
    bus.moving = 1'b0;
    tick();
    chk("stop", 32'(bus.rom_sel), 32'd6);

    // Direction only latched on frame_tick
    bus.dir_req = 2'd0;
    tick();
    chk("dir_up", 32'(bus.rom_sel), 32'd0);
    bus.dir_req = 2'd2;
    repeat (5) cyc();
    @(negedge clk);
    chk("dir_hold", 32'(bus.rom_sel), 32'd0);
    tick();
    chk("dir_left", 32'(bus.rom_sel[2:1]), 32'd2);

    // Right-edge clipping, no wrap to column 0
    bus.LinkX     = 10'd630;
    bus.LinkY     = 10'd0;
    bus.DrawY     = 10'd5;
    bus.rom_index = 4'd9;
    for (int j = 0; j < 16; j++) begin
      automatic int x = (j < 10) ? 630 + j : j - 10;
      bus.DrawX = 10'(x);
      cyc(); cyc();
      @(negedge clk);
      chk("clip_valid", 32'(bus.pixel_valid), 32'(x >= 630));
    end

    // Reset in the middle of a sprite line
    bus.LinkX     = 10'd200;
    bus.LinkY     = 10'd100;
    bus.DrawX     = 10'd205;
    bus.DrawY     = 10'd105;
    bus.rom_index = 4'd7;
    repeat (3) cyc();
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.pixel_valid), 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_valid",   32'(bus.pixel_valid), 32'd0);
    chk("rst_addr",    32'(bus.rom_addr),    32'd0);
    chk("rst_rom_sel", 32'(bus.rom_sel),     32'd2);
    cyc();
    rst_n = 1'b1;
    @(negedge clk); chk("rel0", 32'(bus.pixel_valid), 32'd0);
    @(negedge clk); chk("rel1", 32'(bus.pixel_valid), 32'd0);
    @(negedge clk); chk("rel2", 32'(bus.pixel_valid), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cyc();
      bus.frame_tick = ($urandom_range(0, 29) == 0);
      bus.dir_req    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.moving = ~bus.moving;
      if (bus.frame_tick && $urandom_range(0, 3) == 0) begin
        bus.LinkX = 10'($urandom_range(0, 639));
        bus.LinkY = 10'($urandom_range(0, 479));
      end
      bus.DrawX     = 10'(int'(bus.LinkX) + int'($urandom_range(0, 23)) - 4);
      bus.DrawY     = 10'(int'(bus.LinkY) + int'($urandom_range(0, 23)) - 4);
      bus.rom_index = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
